// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch
// (port 0, "if") and load/store (port 1, "ls"). One transaction in flight at
// a time; load/store has priority, and a starvation counter forces a fetch
// grant after STARVE_LIMIT consecutive lost arbitrations.
//
// Optional build macro: MEM_PORT_ALIGN_CHECK_EN
//   When defined, adds if_resp_err/ls_resp_err. A misaligned accepted request
//   (addr[1:0] != 0) skips the memory access and responds with err=1, rdata=0.
//
// Note: despite its name, nreset is an active-high asynchronous reset.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready to accept one request; readies driven combinationally
// ISSUE | mem_en pulse, latched request presented on the memory port
// WAIT  | memory latency countdown, captures mem_rdata at terminal count
// RESP  | one-cycle response strobe to the winning requester

module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          if_valid,
    output logic          if_ready,
    input  logic [AW-1:0] if_addr,
    output logic          if_resp_valid,
    output logic [DW-1:0] if_resp_rdata,
`ifdef MEM_PORT_ALIGN_CHECK_EN
    output logic          if_resp_err,
`endif
    input  logic          ls_valid,
    output logic          ls_ready,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    input  logic          ls_rw,
    output logic          ls_resp_valid,
    output logic [DW-1:0] ls_resp_rdata,
`ifdef MEM_PORT_ALIGN_CHECK_EN
    output logic          ls_resp_err,
`endif
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rw,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_owner_ls;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_rw;
    logic          r_err;
    logic [3:0]    r_lat_cnt;
    logic [3:0]    r_starve_cnt;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_ls_rdata;

    logic          w_idle;
    logic          w_fetch_turn;
    logic          w_grant_ls;
    logic          w_grant_if;
    logic          w_accept;
    logic          w_misalign;
    logic          w_capture;
    logic [AW-1:0] w_sel_addr;

    // Readies are suppressed while reset is held so every output reads 0.
    assign w_idle       = (r_state == IDLE) && !nreset;
    assign w_fetch_turn = (r_starve_cnt == STARVE_MAX);
    assign w_grant_ls   = ls_valid && !(if_valid && w_fetch_turn);
    assign w_grant_if   = if_valid && !w_grant_ls;
    assign w_accept     = w_idle && (if_valid || ls_valid);
    assign w_sel_addr   = w_grant_ls ? ls_addr : if_addr;

`ifdef MEM_PORT_ALIGN_CHECK_EN
    assign w_misalign   = (w_sel_addr[1:0] != 2'b00);
`else
    assign w_misalign   = 1'b0;
`endif

    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_rw        = r_rw;
    assign if_resp_rdata = r_if_rdata;
    assign ls_resp_rdata = r_ls_rdata;

    // State register.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_next_state  = r_state;
        w_capture     = 1'b0;
        mem_en        = 1'b0;
        if_ready      = 1'b0;
        ls_ready      = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if_ready = w_idle && w_grant_if;
                ls_ready = w_idle && w_grant_ls;
                if (w_accept) begin
                    w_next_state = w_misalign ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_en       = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                if (r_lat_cnt == 4'd0) begin
                    w_capture    = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if_resp_valid = !r_owner_ls;
                ls_resp_valid = r_owner_ls;
                w_next_state  = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

`ifdef MEM_PORT_ALIGN_CHECK_EN
    assign if_resp_err = if_resp_valid && r_err;
    assign ls_resp_err = ls_resp_valid && r_err;
`endif

    // Request latch, latency down-counter and response data capture.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_owner_ls <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rw       <= 1'b0;
            r_err      <= 1'b0;
            r_lat_cnt  <= 4'd0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_owner_ls <= w_grant_ls;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_grant_ls ? ls_wdata : '0;
                r_rw       <= w_grant_ls && ls_rw;
                r_err      <= w_misalign;
                // A rejected misaligned request still gets its data cleared.
                if (w_misalign) begin
                    if (w_grant_ls) begin
                        r_ls_rdata <= '0;
                    end else begin
                        r_if_rdata <= '0;
                    end
                end
            end
            if (r_state == ISSUE) begin
                r_lat_cnt <= LAT_LOAD;
            end else if (r_state == WAIT && r_lat_cnt != 4'd0) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            if (w_capture) begin
                if (r_owner_ls) begin
                    r_ls_rdata <= r_rw ? '0 : mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    // Starvation counter: counts fetch losses while fetch is requesting.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_starve_cnt <= 4'd0;
        end else if (w_accept) begin
            if (w_grant_if) begin
                r_starve_cnt <= 4'd0;
            end else if (if_valid && r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, hand-written
// reset/starvation sequences, then randomized traffic checked every cycle
// against a transaction-timeline reference model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MEM_LAT = 3;
    localparam int STARVE_LIMIT = 4;

    logic          clk = 1'b0;
    logic          nreset = 1'b1;
    logic          if_valid = 1'b0;
    logic          if_ready;
    logic [AW-1:0] if_addr = '0;
    logic          if_resp_valid;
    logic [DW-1:0] if_resp_rdata;
    logic          ls_valid = 1'b0;
    logic          ls_ready;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          ls_rw = 1'b0;
    logic          ls_resp_valid;
    logic [DW-1:0] ls_resp_rdata;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rw;
    logic [DW-1:0] mem_rdata;
`ifdef MEM_PORT_ALIGN_CHECK_EN
    logic          if_resp_err;
    logic          ls_resp_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .nreset(nreset),
        .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata),
`ifdef MEM_PORT_ALIGN_CHECK_EN
        .if_resp_err(if_resp_err),
`endif
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rw(ls_rw),
        .ls_resp_valid(ls_resp_valid), .ls_resp_rdata(ls_resp_rdata),
`ifdef MEM_PORT_ALIGN_CHECK_EN
        .ls_resp_err(ls_resp_err),
`endif
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rw(mem_rw), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0013;
        return (a ^ 32'hA5A5_0F0F) + {a[15:0], a[31:16]};
    endfunction

    assign mem_rdata = memfn(mem_addr);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model (transaction timeline) ----------------
    int          cyc = 0;
    int          m_en_cyc = -1;
    int          m_resp_cyc = -1;
    int          m_free = 0;
    int          m_starve = 0;
    bit          m_owner_ls = 0;
    logic [31:0] m_addr, m_wdata, m_data;
    bit          m_rw = 0;
    bit          m_err = 0;
    logic [31:0] m_if_data = '0;
    logic [31:0] m_ls_data = '0;
    int          m_resps = 0;
    int          act_resps = 0;
    bit          if_acc = 0;
    bit          ls_acc = 0;

    always @(negedge clk) begin
        bit idle, fturn, e_ls, e_if, mis;
        cyc++;
        if (nreset) begin
            m_en_cyc = -1; m_resp_cyc = -1; m_free = 0; m_starve = 0;
            m_if_data = '0; m_ls_data = '0;
            if_acc = 0; ls_acc = 0;
            check("rst_mem_en", mem_en, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_mem_rw", mem_rw, 0);
            check("rst_readies", {if_ready, ls_ready}, 0);
            check("rst_resp_valid", {if_resp_valid, ls_resp_valid}, 0);
            check("rst_if_rdata", if_resp_rdata, 0);
            check("rst_ls_rdata", ls_resp_rdata, 0);
        end else begin
            idle  = (cyc >= m_free);
            fturn = (m_starve == STARVE_LIMIT);
            e_ls  = idle && ls_valid && !(if_valid && fturn);
            e_if  = idle && if_valid && !e_ls;
            check("if_ready", if_ready, e_if);
            check("ls_ready", ls_ready, e_ls);
            check("mem_en", mem_en, cyc == m_en_cyc);
            if (m_en_cyc >= 0 && cyc >= m_en_cyc && cyc < m_resp_cyc) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_wdata", mem_wdata, m_wdata);
                check("mem_rw", mem_rw, m_rw);
            end
            if (cyc == m_resp_cyc) begin
                m_resps++;
                if (m_owner_ls) m_ls_data = m_data;
                else m_if_data = m_data;
            end
            if (if_resp_valid || ls_resp_valid) act_resps++;
            check("if_resp_valid", if_resp_valid, cyc == m_resp_cyc && !m_owner_ls);
            check("ls_resp_valid", ls_resp_valid, cyc == m_resp_cyc && m_owner_ls);
            check("if_resp_rdata", if_resp_rdata, m_if_data);
            check("ls_resp_rdata", ls_resp_rdata, m_ls_data);
`ifdef MEM_PORT_ALIGN_CHECK_EN
            check("if_resp_err", if_resp_err, cyc == m_resp_cyc && !m_owner_ls && m_err);
            check("ls_resp_err", ls_resp_err, cyc == m_resp_cyc && m_owner_ls && m_err);
`endif
            if (e_ls || e_if) begin
                m_owner_ls = e_ls;
                m_addr  = e_ls ? ls_addr : if_addr;
                m_wdata = e_ls ? ls_wdata : '0;
                m_rw    = e_ls && ls_rw;
                m_data  = m_rw ? '0 : memfn(m_addr);
                mis = 0;
`ifdef MEM_PORT_ALIGN_CHECK_EN
                mis = (m_addr[1:0] != 2'b00);
`endif
                m_err = mis;
                if (mis) begin
                    m_data = '0;
                    m_en_cyc = -1;
                    m_resp_cyc = cyc + 1;
                    m_free = cyc + 2;
                end else begin
                    m_en_cyc = cyc + 1;
                    m_resp_cyc = cyc + 2 + MEM_LAT;
                    m_free = cyc + 3 + MEM_LAT;
                end
                if (e_if) m_starve = 0;
                else if (if_valid && m_starve < STARVE_LIMIT) m_starve++;
            end
            if_acc = if_ready;
            ls_acc = ls_ready;
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          iv;
        logic [31:0] ia;
        bit          lv;
        logic [31:0] la;
        logic [31:0] lw;
        bit          lrw;
        bit          exp_ls;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic pulse_reset();
        nreset = 1'b1;
        if_valid = 1'b0;
        ls_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nreset = 1'b0;
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1, idle again.
    task automatic run_txn(input vec_t v, input string nm);
        bit got_if, got_ls, seen, resp_ls;
        int lat, en_cnt;
        logic [31:0] rd;
        if_valid = v.iv; if_addr = v.ia;
        ls_valid = v.lv; ls_addr = v.la; ls_wdata = v.lw; ls_rw = v.lrw;
        got_if = 0; got_ls = 0;
        for (int k = 0; k < 8 && !(got_if || got_ls); k++) begin
            @(negedge clk);
            got_if = if_ready;
            got_ls = ls_ready;
        end
        check({nm, "_granted"}, got_if || got_ls, 1);
        check({nm, "_winner_ls"}, got_ls, v.exp_ls);
        @(posedge clk); #1;
        if_valid = 1'b0; ls_valid = 1'b0;
        seen = 0; lat = 0; en_cnt = 0; resp_ls = 0; rd = '0;
        for (int k = 1; k <= MEM_LAT + 8 && !seen; k++) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (if_resp_valid || ls_resp_valid) begin
                seen = 1; lat = k; resp_ls = ls_resp_valid;
                rd = ls_resp_valid ? ls_resp_rdata : if_resp_rdata;
            end
        end
        check({nm, "_resp_seen"}, seen, 1);
        check({nm, "_latency"}, lat, MEM_LAT + 2);
        check({nm, "_mem_en_count"}, en_cnt, 1);
        check({nm, "_resp_port_ls"}, resp_ls, v.exp_ls);
        check({nm, "_rdata"}, rd, v.exp_rdata);
        @(posedge clk); #1;
    endtask

    task automatic rand_drive();
        if (!if_valid || if_acc) begin
            if_valid = ($urandom_range(0, 2) != 0);
            if_addr = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        end else if ($urandom_range(0, 15) == 0) begin
            if_valid = 1'b0;
        end
        if (!ls_valid || ls_acc) begin
            ls_valid = ($urandom_range(0, 2) != 0);
            ls_addr = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ls_wdata = $urandom;
            ls_rw = $urandom_range(0, 1);
        end else if ($urandom_range(0, 15) == 0) begin
            ls_valid = 1'b0;
        end
    endtask

    initial begin
        int bad_resp;
        vec_t v;
        vecs[0] = '{1, 32'h8000_0000, 0, 32'h0, 32'h0, 0, 0, 32'h0000_0013};
        vecs[1] = '{0, 32'h0, 1, 32'h8000_1000, 32'hDEAD_BEEF, 1, 1, 32'h0};
        vecs[2] = '{0, 32'h0, 1, 32'h0000_0040, 32'h1234_5678, 0, 1, memfn(32'h0000_0040)};
        for (int i = 3; i <= 8; i++) begin
            vecs[i].iv = 1; vecs[i].ia = 32'h100 + 32'(i * 4);
            vecs[i].lv = 1; vecs[i].la = 32'h2000 + 32'(i * 4);
            vecs[i].lw = 32'hCAFE_0000 + 32'(i); vecs[i].lrw = 0;
            vecs[i].exp_ls = (i != 7);
            vecs[i].exp_rdata = (i != 7) ? memfn(vecs[i].la) : memfn(vecs[i].ia);
        end
        vecs[9] = '{1, 32'h0000_1000, 0, 32'h0, 32'h0, 0, 0, memfn(32'h0000_1000)};

        @(posedge clk); #1;
        @(posedge clk); #1;
        nreset = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted while waiting on memory: the transaction is dropped.
        ls_valid = 1'b1; ls_addr = 32'h0000_0300; ls_rw = 1'b0; ls_wdata = '0;
        for (int k = 0; k < 8 && !ls_ready; k++) @(negedge clk);
        check("rstw_accepted", ls_ready, 1);
        @(posedge clk); #1;
        ls_valid = 1'b0;
        @(posedge clk); #1;
        pulse_reset();
        bad_resp = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if_resp_valid || ls_resp_valid) bad_resp++;
        end
        check("rstw_no_resp", bad_resp, 0);
        @(posedge clk); #1;
        v = '{1, 32'h8000_0000, 0, 32'h0, 32'h0, 0, 0, 32'h0000_0013};
        run_txn(v, "post_rst");

        // Continuous contention: grant pattern ls x4, then fetch.
        bad_resp = 0;
        if_valid = 1'b1; if_addr = 32'h0000_0500;
        ls_valid = 1'b1; ls_addr = 32'h0000_0600; ls_rw = 1'b0;
        for (int g = 0; g < 6; g++) begin
            bit got_if, got_ls;
            got_if = 0; got_ls = 0;
            for (int k = 0; k < MEM_LAT + 8 && !(got_if || got_ls); k++) begin
                @(negedge clk);
                got_if = if_ready; got_ls = ls_ready;
            end
            check($sformatf("contend%0d_winner_ls", g), got_ls, g != 4);
            check($sformatf("contend%0d_granted", g), got_if || got_ls, 1);
            @(posedge clk); #1;
        end
        if_valid = 1'b0; ls_valid = 1'b0;
        for (int k = 0; k < MEM_LAT + 4; k++) begin @(posedge clk); #1; end

`ifdef MEM_PORT_ALIGN_CHECK_EN
        begin
            int en_cnt, errs;
            ls_valid = 1'b1; ls_addr = 32'h8000_0002; ls_rw = 1'b0;
            for (int k = 0; k < 8 && !ls_ready; k++) @(negedge clk);
            check("align_accepted", ls_ready, 1);
            @(posedge clk); #1;
            ls_valid = 1'b0;
            en_cnt = 0; errs = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (mem_en) en_cnt++;
                if (ls_resp_valid && ls_resp_err && ls_resp_rdata == 0) errs++;
            end
            check("align_no_mem_en", en_cnt, 0);
            check("align_err_resp", errs, 1);
            @(posedge clk); #1;
        end
`endif

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) pulse_reset();
            rand_drive();
            @(posedge clk); #1;
        end
        if_valid = 1'b0; ls_valid = 1'b0;
        for (int k = 0; k < MEM_LAT + 6; k++) begin @(posedge clk); #1; end
        check("resp_count", act_resps, m_resps);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
